// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode, ALU and controller state encodings shared by the sequencer.
package cpu_pkg;
  typedef enum logic [2:0] {OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP} opcode_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_XOR, ALU_PASS} alu_op_e;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_SKIP, S_MEM_RD, S_MEM_WR, S_HALT, S_ERROR} state_e;
  function automatic alu_op_e alu_of(opcode_e op);
    return op == OP_ADD ? ALU_ADD : op == OP_AND ? ALU_AND : op == OP_XOR ? ALU_XOR : ALU_PASS;
  endfunction
endpackage

// File: rtl/seq_controller.sv
// seq_controller: accumulator-CPU sequencer FSM with memory-ack timeout and retired-instruction count.
module seq_controller
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic        acc_z,
  input  logic        mem_ack,
  input  logic        resume,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        jump,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        acc_src,
  output logic        acc_wr,
  output logic [1:0]  alu_op,
  output logic        halted,
  output logic        bus_err,
  output logic [15:0] instr_cnt
);
  state_e state, next;
  opcode_e op, op_q;
  logic [3:0] wait_cnt;
  logic in_mem, timeout, retire;
  assign op = opcode_e'(opcode);
  assign in_mem = state == S_MEM_RD || state == S_MEM_WR;
  assign timeout = !mem_ack && wait_cnt == 4'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_FETCH;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q      <= OP_HLT;
      wait_cnt  <= '0;
      instr_cnt <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (state == S_DECODE) op_q <= op;
      wait_cnt <= in_mem ? wait_cnt + 4'd1 : 4'd0;
      if (retire) instr_cnt <= instr_cnt + 16'd1;
      if (next == S_ERROR) bus_err <= 1'b1;
    end
  always_comb begin
    next = state;
    case (state)
      S_FETCH:          next = S_DECODE;
      S_DECODE:         next = op == OP_HLT ? S_HALT :
                               op == OP_JMP ? S_FETCH :
                               op == OP_SKZ ? (acc_z ? S_SKIP : S_FETCH) :
                               op == OP_STO ? S_MEM_WR : S_MEM_RD;
      S_SKIP:           next = S_FETCH;
      S_MEM_RD, S_MEM_WR: next = mem_ack ? S_FETCH : timeout ? S_ERROR : state;
      S_HALT:           next = resume ? S_FETCH : S_HALT;
      default:          next = S_ERROR;
    endcase
  end
  // Strobes are gated by rst so an asserted reset silences them combinationally.
  always_comb begin
    ir_ld   = !rst && state == S_FETCH;
    jump    = !rst && state == S_DECODE && op == OP_JMP;
    mem_rd  = !rst && state == S_MEM_RD;
    mem_wr  = !rst && state == S_MEM_WR;
    acc_wr  = mem_rd && mem_ack;
    acc_src = acc_wr && op_q == OP_LDA;
    halted  = !rst && state == S_HALT;
    pc_inc  = !rst && ((state == S_DECODE && op == OP_SKZ) || state == S_SKIP ||
                       (in_mem && mem_ack) || (state == S_HALT && resume));
    retire  = !rst && (jump || (state == S_DECODE && op == OP_SKZ && !acc_z) || state == S_SKIP ||
                       (in_mem && mem_ack) || (state == S_HALT && resume));
    alu_op  = state == S_MEM_RD ? alu_of(op_q) : ALU_PASS;
  end
endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed per-cycle vectors scored against a queue of hand-derived expectations.
module tb_seq_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic acc_z = 1'b0, mem_ack = 1'b0, resume = 1'b0;
  logic ir_ld, pc_inc, jump, mem_rd, mem_wr, acc_src, acc_wr, halted, bus_err;
  logic [1:0] alu_op;
  logic [15:0] instr_cnt;
  typedef struct {
    logic [10:0] o;
    logic [15:0] cnt;
    string       n;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  logic [10:0] act;
  int vectors = 0, miscompares = 0;
  logic [15:0] ecnt = 16'd0;
  // bit order: ir_ld pc_inc jump mem_rd mem_wr acc_src acc_wr alu_op[1:0] halted bus_err
  localparam logic [10:0] FE   = 11'b1000000_11_00;
  localparam logic [10:0] IDLE = 11'b0000000_11_00;
  localparam logic [10:0] PCI  = 11'b0100000_11_00;
  localparam logic [10:0] JMPV = 11'b0010000_11_00;
  localparam logic [10:0] HLTD = 11'b0000000_11_10;
  localparam logic [10:0] RESV = 11'b0100000_11_10;
  localparam logic [10:0] ERR  = 11'b0000000_11_01;
  localparam logic [10:0] WRW  = 11'b0000100_11_00;
  localparam logic [10:0] WRA  = 11'b0100100_11_00;
  seq_controller #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .acc_z(acc_z), .mem_ack(mem_ack), .resume(resume),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .jump(jump), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .acc_src(acc_src), .acc_wr(acc_wr), .alu_op(alu_op), .halted(halted), .bus_err(bus_err),
    .instr_cnt(instr_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (q.size() > 0) begin
      e_m = q.pop_front();
      act = {ir_ld, pc_inc, jump, mem_rd, mem_wr, acc_src, acc_wr, alu_op, halted, bus_err};
      vectors++;
      if (act !== e_m.o || instr_cnt !== e_m.cnt) begin
        miscompares++;
        $display("FAIL %s: got out=%b cnt=%h, expected out=%b cnt=%h", e_m.n, act, instr_cnt, e_m.o, e_m.cnt);
      end
    end
  function automatic logic [1:0] aop(logic [2:0] op);
    return op == 3'b010 ? 2'b00 : op == 3'b011 ? 2'b01 : op == 3'b100 ? 2'b10 : 2'b11;
  endfunction
  task automatic step(string n, bit r, logic [2:0] op, bit az, bit ack, bit res, logic [10:0] eo, bit ret);
    rst = r; opcode = op; acc_z = az; mem_ack = ack; resume = res;
    if (r) ecnt = 16'd0;
    q.push_back('{eo, ecnt, n});
    @(posedge clk); #1;
    if (ret) ecnt++;
  endtask
  task automatic mem_instr(string n, logic [2:0] op, int waits, bit ack_noise);
    bit rd;
    logic [10:0] w, a;
    rd = op != 3'b110;
    w = rd ? {7'b0001000, aop(op), 2'b00} : WRW;
    a = rd ? {5'b01010, op == 3'b101, 1'b1, aop(op), 2'b00} : WRA;
    step({n, "/fetch"}, 0, op, 0, ack_noise, 0, FE, 0);
    step({n, "/decode"}, 0, op, 0, ack_noise, 0, IDLE, 0);
    for (int i = 0; i < waits; i++) step({n, "/wait"}, 0, 3'b000, 0, 0, 0, w, 0);
    step({n, "/ack"}, 0, 3'b000, 0, 1, 0, a, 1);
  endtask
  task automatic jmp(string n);
    step({n, "/fetch"}, 0, 3'b111, 0, 0, 0, FE, 0);
    step({n, "/decode"}, 0, 3'b111, 0, 0, 0, JMPV, 1);
  endtask
  initial begin
    @(posedge clk); #1;
    step("reset", 1, 3'b101, 0, 0, 0, IDLE, 0);
    mem_instr("lda", 3'b101, 1, 0);
    mem_instr("add", 3'b010, 0, 1);
    mem_instr("and", 3'b011, 2, 0);
    mem_instr("xor", 3'b100, 1, 0);
    mem_instr("sto", 3'b110, 1, 1);
    step("skz1/fetch", 0, 3'b001, 1, 0, 0, FE, 0);
    step("skz1/decode", 0, 3'b001, 1, 0, 0, PCI, 0);
    step("skz1/skip", 0, 3'b001, 0, 0, 0, PCI, 1);
    step("skz0/fetch", 0, 3'b001, 0, 0, 0, FE, 0);
    step("skz0/decode", 0, 3'b001, 0, 0, 0, PCI, 1);
    jmp("jmp");
    step("hlt/fetch", 0, 3'b000, 0, 0, 0, FE, 0);
    step("hlt/decode", 0, 3'b000, 0, 0, 0, IDLE, 0);
    for (int i = 0; i < 5; i++) step("hlt/hold", 0, 3'b111, 0, i == 2, 0, HLTD, 0);
    step("hlt/resume", 0, 3'b111, 0, 0, 1, RESV, 1);
    step("resume_ign/fetch", 0, 3'b111, 0, 0, 1, FE, 0);
    step("resume_ign/decode", 0, 3'b111, 0, 0, 1, JMPV, 1);
    mem_instr("ack_at_limit", 3'b101, 14, 0);
    step("ack_at_limit/no_err", 0, 3'b111, 0, 0, 0, FE, 0);
    step("midrst/decode", 0, 3'b101, 0, 0, 0, IDLE, 0);
    step("midrst/wait", 0, 3'b101, 0, 0, 0, 11'b0001000_11_00, 0);
    step("midrst/assert", 1, 3'b101, 0, 1, 0, IDLE, 0);
    for (int i = 0; i < 65535; i++) jmp("burst");
    step("wrap/at_ffff", 0, 3'b111, 0, 0, 0, FE, 0);
    step("wrap/decode", 0, 3'b111, 0, 0, 0, JMPV, 1);
    step("wrap/at_0000", 0, 3'b110, 0, 0, 0, FE, 0);
    step("tmo/decode", 0, 3'b110, 0, 0, 0, IDLE, 0);
    for (int i = 0; i < 15; i++) step("tmo/mem_wr", 0, 3'b110, 0, 0, 0, WRW, 0);
    step("tmo/error", 0, 3'b110, 0, 0, 0, ERR, 0);
    step("tmo/error_noise", 0, 3'b000, 1, 1, 1, ERR, 0);
    step("tmo/error_hold", 0, 3'b111, 0, 1, 0, ERR, 0);
    step("tmo/reset", 1, 3'b000, 0, 0, 0, IDLE, 0);
    step("post_reset/fetch", 0, 3'b000, 0, 0, 0, FE, 0);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for mem_ack before faulting (range 1..15).
REQ-002 SHALL have port clk  input  1  single system clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port opcode  input  3  instruction opcode from the datapath instruction register.
REQ-005 SHALL have port acc_z  input  1  accumulator-is-zero flag.
REQ-006 SHALL have port mem_ack  input  1  data-memory transfer complete, sampled while mem_rd or mem_wr is high.
REQ-007 SHALL have port resume  input  1  leave HALT.
REQ-008 SHALL have ports ir_ld, pc_inc, jump  output  1 each  load IR, increment PC, load PC from operand.
REQ-009 SHALL have ports mem_rd, mem_wr  output  1 each  data-memory read and write requests.
REQ-010 SHALL have ports acc_src, acc_wr  output  1 each  accumulator source (0 = ALU, 1 = memory data) and accumulator write enable.
REQ-011 SHALL have port alu_op  output  2  ALU operation: 00 = ADD, 01 = AND, 10 = XOR, 11 = PASS.
REQ-012 SHALL have ports halted, bus_err  output  1 each  in HALT, sticky timeout fault.
REQ-013 SHALL have port instr_cnt  output  16  retired-instruction count, wraps modulo 2^16.

Function
REQ-014 SHALL decode opcodes as 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
REQ-015 SHALL implement a Moore/Mealy FSM with states FETCH, DECODE, SKIP, MEM_RD, MEM_WR, HALT, ERROR.
REQ-016 In FETCH, SHALL assert ir_ld for exactly one cycle and then move to DECODE.
REQ-017 In DECODE with HLT, SHALL move to HALT with no pc_inc.
REQ-018 In DECODE with JMP, SHALL assert jump for one cycle, move to FETCH and retire.
REQ-019 In DECODE with SKZ, SHALL assert pc_inc; if acc_z=1 it SHALL move to SKIP, otherwise to FETCH and retire.
REQ-020 In SKIP, SHALL assert pc_inc once more, then move to FETCH and retire; acc_z is sampled in DECODE only.
REQ-021 In DECODE with ADD, AND, XOR or LDA, SHALL move to MEM_RD; with STO it SHALL move to MEM_WR.
REQ-022 In MEM_RD, SHALL hold mem_rd=1 until mem_ack; in the ack cycle it SHALL assert acc_wr and pc_inc, set acc_src=1 for LDA and 0 otherwise, then move to FETCH and retire.
REQ-023 SHALL drive alu_op from the latched opcode in MEM_RD and to PASS in every other state.
REQ-024 In MEM_WR, SHALL hold mem_wr=1 until mem_ack; in the ack cycle it SHALL assert pc_inc, then move to FETCH and retire.
REQ-025 SHALL never assert mem_rd and mem_wr together.
REQ-026 SHALL ignore mem_ack outside MEM_RD and MEM_WR.
REQ-027 SHALL clear a 4-bit wait counter on entry to MEM_RD or MEM_WR and increment it each cycle without ack.
REQ-028 If the wait counter reaches TIMEOUT without ack, SHALL drop the request, move to ERROR and set bus_err.
REQ-029 An ack arriving in the same cycle the timeout is reached SHALL win, and no fault SHALL be raised.
REQ-030 ERROR SHALL be terminal until rst, with all strobes low.
REQ-031 In HALT, SHALL hold halted=1; resume=1 SHALL assert pc_inc, retire the HLT instruction and move to FETCH.
REQ-032 resume SHALL be ignored outside HALT.
REQ-033 SHALL increment instr_cnt by 1 on each retire, wrapping from 0xFFFF to 0x0000.
REQ-034 SHALL make all strobes single-cycle pulses except mem_rd, mem_wr and halted.

Reset
REQ-035 On rst=1, SHALL force the state to FETCH, the wait counter to 0, instr_cnt to 0 and bus_err to 0, and drive all strobes and halted to 0, asynchronously.
REQ-036 Reset asserted mid-transfer SHALL drop mem_rd/mem_wr immediately with no acc_wr or pc_inc.
REQ-037 After rst deasserts, SHALL assert ir_ld in the first clock cycle.

Structure
REQ-038 SHALL place opcode encodings, alu_op encodings and state encodings in shared package cpu_pkg.
REQ-039 SHALL keep the FSM and counters in one module; the decode SHALL be inlined, with no sub-module.

Verification
REQ-040 Bench SHALL apply reset, then LDA with ack on the 2nd MEM_RD cycle, and SHALL see ir_ld at cycle 1, mem_rd for 2 cycles, acc_wr=1 with acc_src=1 in the ack cycle, and instr_cnt=1.
REQ-041 Bench SHALL run SKZ with acc_z=1 and SHALL see pc_inc in DECODE and SKIP (2 pulses); with acc_z=0 it SHALL see 1 pulse.
REQ-042 Bench SHALL issue STO with mem_ack held low and TIMEOUT=15, and SHALL see mem_wr high for 15 cycles, then bus_err=1 and ERROR held until rst.
REQ-043 Bench SHALL execute HLT, hold 5 cycles and pulse resume, and SHALL see halted=1 throughout, then pc_inc and ir_ld on the following cycle.
REQ-044 Bench SHALL preload instr_cnt to 0xFFFF via 65535 JMPs, retire one more, and SHALL see instr_cnt=0x0000.
REQ-045 Bench SHALL assert rst during the MEM_RD wait and SHALL see mem_rd=0 immediately, no acc_wr, and instr_cnt=0.
